// File: rtl/sad_accum_if.sv
// Handshake bundle between the abs-difference stage, sad_accum and the result consumer.
// When SAD_ACCUM_SAT_EN is defined, the bundle also carries the sticky saturation flag.
interface sad_accum_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned SUM_W = 7
);
  logic             start;
  logic [W-1:0]     dif_in;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] count;
`ifdef SAD_ACCUM_SAT_EN
  logic             sat;
`endif

  // Drives start, samples and result acceptance; observes status.
  modport master (
    output start, dif_in, in_valid, out_ready,
`ifdef SAD_ACCUM_SAT_EN
    input  sat,
`endif
    input  in_ready, sum_out, out_valid, busy, count
  );

  // The accumulator side.
  modport slave (
    input  start, dif_in, in_valid, out_ready,
`ifdef SAD_ACCUM_SAT_EN
    output sat,
`endif
    output in_ready, sum_out, out_valid, busy, count
  );
endinterface

// File: rtl/sad_accum.sv
// Sum-of-absolute-differences accumulator. Collects N_SAMPLES differences per frame and
// offers the total on a valid/ready output. All outputs come straight from flops.
// Optional feature macro: SAD_ACCUM_SAT_EN (saturating add plus sticky sat flag);
// without it the sum wraps modulo 2^SUM_W.
module sad_accum #(
  parameter int unsigned W         = 4,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned SUM_W     = 7
) (
  input logic         clk,
  input logic         rst_n,
  sad_accum_if.slave  bus
);

  // Reject configurations the counter cannot represent.
  if (N_SAMPLES < 1 || N_SAMPLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("sad_accum: N_SAMPLES must be in 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic [SUM_W-1:0] sum_next;
  logic             accept;
  logic             last;
`ifdef SAD_ACCUM_SAT_EN
  logic             sat;
  logic [SUM_W:0]   sum_wide;
  logic             clip;
`endif

  // Next accumulator value and handshake decode for the current cycle.
  always_comb begin
    accept = in_ready & bus.in_valid;
    last   = (count == CNT_W'(N_SAMPLES - 1));
`ifdef SAD_ACCUM_SAT_EN
    sum_wide = {1'b0, sum} + (SUM_W + 1)'(bus.dif_in);
    clip     = sum_wide[SUM_W];
    sum_next = clip ? '1 : sum_wide[SUM_W-1:0];
`else
    sum_next = sum + SUM_W'(bus.dif_in);
`endif
  end

  // Frame FSM; handshake/status flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      sum       <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SAD_ACCUM_SAT_EN
      sat       <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (bus.start) begin
            state    <= StAccum;
            sum      <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef SAD_ACCUM_SAT_EN
            sat      <= 1'b0;
`endif
          end
        end
        StAccum: begin
          if (accept) begin
            sum   <= sum_next;
            count <= count + 1'b1;
`ifdef SAD_ACCUM_SAT_EN
            sat   <= sat | clip;
`endif
            // The N_SAMPLES-th accept closes the frame; result is visible next cycle.
            if (last) begin
              state     <= StDone;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        StDone: begin
          // start is deliberately ignored here, even on the handshake cycle.
          if (bus.out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are direct flop copies.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.busy      = busy;
    bus.sum_out   = sum;
    bus.count     = count;
`ifdef SAD_ACCUM_SAT_EN
    bus.sat       = sat;
`endif
  end

endmodule

// File: tb/tb_sad_accum.sv
// Scoreboard bench for sad_accum: default build, an N_SAMPLES=1 instance and a SUM_W=5
// instance for wrap/saturation. Expected results are queued at stimulus time and popped
// by per-instance monitors on each output handshake.
module tb_sad_accum;

  typedef struct {
    int sum;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q5[$];
  exp_t e0, e1, e5;

  always #5 clk = ~clk;

  sad_accum_if #(.W(4), .CNT_W(4), .SUM_W(7)) b ();
  sad_accum_if #(.W(4), .CNT_W(4), .SUM_W(7)) b1 ();
  sad_accum_if #(.W(4), .CNT_W(4), .SUM_W(5)) b5 ();

  sad_accum #(.W(4), .N_SAMPLES(8), .CNT_W(4), .SUM_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  sad_accum #(.W(4), .N_SAMPLES(1), .CNT_W(4), .SUM_W(7)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  sad_accum #(.W(4), .N_SAMPLES(8), .CNT_W(4), .SUM_W(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && b.out_valid && b.out_ready) begin
      if (q0.size() == 0) chk("sb0_unexpected_result", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("sb0_sum", 32'(b.sum_out), e0.sum);
        chk("sb0_count", 32'(b.count), e0.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) chk("sb1_unexpected_result", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("sb1_sum", 32'(b1.sum_out), e1.sum);
        chk("sb1_count", 32'(b1.count), e1.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b5.out_valid && b5.out_ready) begin
      if (q5.size() == 0) chk("sb5_unexpected_result", 1, 0);
      else begin
        e5 = q5.pop_front();
        chk("sb5_sum", 32'(b5.sum_out), e5.sum);
        chk("sb5_count", 32'(b5.count), e5.cnt);
      end
    end
  end

  // Tasks are entered #1 after a rising edge and return #1 after one.
  task automatic start_frame();
    b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    b.in_valid = 1'b1;
    b.dif_in   = d;
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.dif_in   = 'x;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    b.start = 0;  b.dif_in = 0;  b.in_valid = 0;  b.out_ready = 1;
    b1.start = 0; b1.dif_in = 0; b1.in_valid = 0; b1.out_ready = 1;
    b5.start = 0; b5.dif_in = 0; b5.in_valid = 0; b5.out_ready = 1;

    // Reset values.
    #3;
    chk("rst_in_ready", 32'(b.in_ready), 0);
    chk("rst_out_valid", 32'(b.out_valid), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_sum", 32'(b.sum_out), 0);
    chk("rst_count", 32'(b.count), 0);
    #14 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a frame after three accepts.
    start_frame();
    chk("accum_in_ready", 32'(b.in_ready), 1);
    chk("accum_busy", 32'(b.busy), 1);
    send(4'd5); send(4'd6); send(4'd7);
    chk("pre_rst_sum", 32'(b.sum_out), 18);
    chk("pre_rst_count", 32'(b.count), 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(b.in_ready), 0);
    chk("midrst_sum", 32'(b.sum_out), 0);
    chk("midrst_count", 32'(b.count), 0);
    chk("midrst_busy", 32'(b.busy), 0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_busy", 32'(b.busy), 0);
    chk("postrst_in_ready", 32'(b.in_ready), 0);
    chk("postrst_out_valid", 32'(b.out_valid), 0);

    // Nominal frame 1..8.
    q0.push_back('{sum: 36, cnt: 8});
    start_frame();
    for (int i = 1; i <= 8; i++) send(4'(i));
    chk("nom_out_valid", 32'(b.out_valid), 1);
    chk("nom_in_ready", 32'(b.in_ready), 0);
    @(posedge clk); #1;
    chk("nom_idle_busy", 32'(b.busy), 0);
    chk("nom_idle_out_valid", 32'(b.out_valid), 0);
    chk("nom_idle_sum", 32'(b.sum_out), 36);
    chk("nom_idle_count", 32'(b.count), 8);

    // Gapped input, eight samples of 15.
    q0.push_back('{sum: 120, cnt: 8});
    start_frame();
    chk("gap_start_sum", 32'(b.sum_out), 0);
    chk("gap_start_count", 32'(b.count), 0);
    for (int i = 0; i < 8; i++) begin
      send(4'd15);
      chk("gap_count", 32'(b.count), i + 1);
      chk("gap_sum", 32'(b.sum_out), 15 * (i + 1));
      if (i < 7) begin
        @(posedge clk); #1;
        chk("gap_hold_count", 32'(b.count), i + 1);
        chk("gap_hold_sum", 32'(b.sum_out), 15 * (i + 1));
      end
    end
    chk("gap_out_valid", 32'(b.out_valid), 1);
    @(posedge clk); #1;
    chk("gap_idle_sum", 32'(b.sum_out), 120);

    // Backpressure in DONE with start and in_valid pulsed.
    b.out_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 8; i++) send(4'd2);
    for (int i = 0; i < 5; i++) begin
      b.start = 1'b1;
      b.in_valid = 1'b1;
      b.dif_in = 4'd5;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(b.out_valid), 1);
      chk("bp_sum", 32'(b.sum_out), 16);
      chk("bp_count", 32'(b.count), 8);
      chk("bp_in_ready", 32'(b.in_ready), 0);
    end
    q0.push_back('{sum: 16, cnt: 8});
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    chk("bp_release_out_valid", 32'(b.out_valid), 0);
    chk("bp_release_busy", 32'(b.busy), 0);
    @(posedge clk); #1;
    chk("bp_no_new_frame", 32'(b.busy), 0);
    chk("bp_kept_sum", 32'(b.sum_out), 16);

    // N_SAMPLES=1 instance.
    q1.push_back('{sum: 9, cnt: 1});
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    b1.in_valid = 1'b1;
    b1.dif_in = 4'd9;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    chk("n1_out_valid", 32'(b1.out_valid), 1);
    @(posedge clk); #1;
    chk("n1_idle_busy", 32'(b1.busy), 0);
    chk("n1_idle_sum", 32'(b1.sum_out), 9);

    // SUM_W=5 instance, sum 120 overflows.
`ifdef SAD_ACCUM_SAT_EN
    q5.push_back('{sum: 31, cnt: 8});
`else
    q5.push_back('{sum: 24, cnt: 8});
`endif
    b5.start = 1'b1;
    @(posedge clk); #1;
    b5.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b5.in_valid = 1'b1;
      b5.dif_in = 4'd15;
      @(posedge clk); #1;
    end
    b5.in_valid = 1'b0;
    chk("ovf_out_valid", 32'(b5.out_valid), 1);
`ifdef SAD_ACCUM_SAT_EN
    chk("ovf_sat_done", 32'(b5.sat), 1);
`endif
    @(posedge clk); #1;
`ifdef SAD_ACCUM_SAT_EN
    chk("ovf_sat_idle", 32'(b5.sat), 1);
    chk("ovf_sum_idle", 32'(b5.sum_out), 31);
`else
    chk("ovf_sum_idle", 32'(b5.sum_out), 24);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    chk("sb5_drained", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
